// File: rtl/pipe_arb_ctrl.sv
// Two-requester arbiter and tag tracker for a fixed-latency pipe with no internal handshake.
// Optional macro PIPE_ARB_PRIO_EN selects fixed priority (req0 wins) instead of round-robin.
module pipe_arb_ctrl #(
  parameter int LAT = 4,
  parameter int IW  = 2,
  parameter int OW  = 4,
  localparam int CW = $clog2(LAT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [IW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [IW-1:0] req1_data,
  output logic          req1_ready,
  output logic          pipe_en,
  output logic [IW-1:0] pipe_in,
  input  logic [OW-1:0] pipe_out,
  output logic          res_valid,
  output logic          res_id,
  output logic [OW-1:0] res_data,
  input  logic          res_ready,
  input  logic          drain_req,
  output logic          drain_done,
  output logic [CW-1:0] inflight
);

  typedef enum logic [0:0] {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_r, state_s;
  logic [LAT-1:0]  valid_r, id_r;
  logic [CW-1:0]   inflight_r;
  logic            stall_s, issue_ok_s;
  logic            grant0_s, grant1_s, grant_any_s, accept_s;
`ifndef PIPE_ARB_PRIO_EN
  logic            rr_r;
  logic            contention_s;
`endif

  assign res_valid  = valid_r[LAT-1];
  assign res_id     = id_r[LAT-1];
  assign res_data   = pipe_out;
  assign stall_s    = res_valid & ~res_ready;
  assign pipe_en    = ~stall_s;
  assign issue_ok_s = (state_r == RUN) & ~stall_s;
  assign accept_s   = res_valid & res_ready;
  assign grant_any_s = grant0_s | grant1_s;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign inflight   = inflight_r;
  // drain_req is included so drain_done drops in the cycle the request is withdrawn.
  assign drain_done = (state_r == DRAIN) & (inflight_r == CW'(0)) & drain_req;
`ifndef PIPE_ARB_PRIO_EN
  assign contention_s = issue_ok_s & req0_valid & req1_valid;
`endif

  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (issue_ok_s) begin
      if (req0_valid && req1_valid) begin
`ifdef PIPE_ARB_PRIO_EN
        grant0_s = 1'b1;
`else
        if (rr_r) begin
          grant1_s = 1'b1;
        end else begin
          grant0_s = 1'b1;
        end
`endif
      end else begin
        grant0_s = req0_valid;
        grant1_s = req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  always_comb begin
    pipe_in = IW'(0);
    if (grant1_s) begin
      pipe_in = req1_data;
    end else if (grant0_s) begin
      pipe_in = req0_data;
    end else begin
      pipe_in = IW'(0);
    end
  end

  always_comb begin
    state_s = state_r;
    case (state_r)
      RUN:     state_s = drain_req ? DRAIN : RUN;
      DRAIN:   state_s = drain_req ? DRAIN : RUN;
      default: state_s = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Tags travel with the pipe so each result emerges with its owner; reset drops stale entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      id_r    <= '0;
    end else if (pipe_en) begin
      for (int i = LAT - 1; i > 0; i--) begin
        valid_r[i] <= valid_r[i-1];
        id_r[i]    <= id_r[i-1];
      end
      valid_r[0] <= grant_any_s;
      id_r[0]    <= grant1_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= CW'(0);
    end else begin
      case ({grant_any_s, accept_s})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

`ifndef PIPE_ARB_PRIO_EN
  // Pointer only moves when both requesters competed for the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_r <= 1'b0;
    end else if (contention_s) begin
      rr_r <= ~rr_r;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_arb_ctrl.sv
// Scoreboard bench for pipe_arb_ctrl with a 4-stage behavioural pipe: result = ((in+1)*12) mod 16.
module tb_pipe_arb_ctrl;
  localparam int LAT = 4;
  localparam int IW  = 2;
  localparam int OW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [IW-1:0] req0_data, req1_data, pipe_in;
  logic          pipe_en, res_valid, res_id, res_ready, drain_req, drain_done;
  logic [OW-1:0] pipe_out, res_data;
  logic [2:0]    inflight;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  logic [4:0] sb_q[$];
  logic [IW-1:0] stg [LAT];

  always #5 clk = ~clk;

  pipe_arb_ctrl #(.LAT(LAT), .IW(IW), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .pipe_en(pipe_en), .pipe_in(pipe_in), .pipe_out(pipe_out),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_ready(res_ready),
    .drain_req(drain_req), .drain_done(drain_done), .inflight(inflight)
  );

  function automatic logic [3:0] pf(input logic [1:0] x);
    int v;
    v = (int'(x) + 1) * 12;
    return 4'(v % 16);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 2'd0; req1_data = 2'd0;
    res_ready = 1'b1; drain_req = 1'b0;
    repeat (n) tick();
  endtask

  // Behavioural pipe: no reset, so stale data keeps flowing after a reset.
  always @(posedge clk) begin
    if (pipe_en) begin
      for (int i = LAT - 1; i > 0; i--) stg[i] <= stg[i-1];
      stg[0] <= pipe_in;
    end
  end
  assign pipe_out = pf(stg[LAT-1]);

  // Scoreboard: push on grant, pop and compare on accepted result.
  always @(negedge clk) begin
    logic [4:0] e;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      check_eq("inflight", 32'(inflight), 32'(sb_q.size()));
      check_eq("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
      if (res_valid && res_ready) begin
        check_eq("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          acc_cnt++;
          check_eq("res_id", 32'(res_id), 32'(e[4]));
          check_eq("res_data", 32'(res_data), 32'(e[3:0]));
        end
      end
      if (req0_ready) sb_q.push_back({1'b0, pf(req0_data)});
      if (req1_ready) sb_q.push_back({1'b1, pf(req1_data)});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g;
    int acc0;
    logic [3:0] exp_d;
    logic [3:0] single_tbl [4];
    single_tbl[0] = 4'd12; single_tbl[1] = 4'd8; single_tbl[2] = 4'd4; single_tbl[3] = 4'd0;

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 2'd0; req1_data = 2'd0;
    res_ready = 1'b1; drain_req = 1'b0;
    @(negedge clk);
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_req0_ready", 32'(req0_ready), 32'd0);
    check_eq("rst_req1_ready", 32'(req1_ready), 32'd0);
    check_eq("rst_drain_done", 32'(drain_done), 32'd0);
    check_eq("rst_pipe_en", 32'(pipe_en), 32'd1);
    check_eq("rst_inflight", 32'(inflight), 32'd0);
    tick();
    rst_n = 1'b1;
    idle(2);

    // Single issue: results 12,8,4,0 in cycles 4..7.
    for (int c = 0; c < 10; c++) begin
      req0_valid = (c < 4);
      req0_data = 2'(c);
      @(negedge clk);
      check_eq("si_res_valid", 32'(res_valid), 32'((c >= 4) && (c <= 7)));
      if (c >= 4 && c <= 7) begin
        exp_d = single_tbl[c-4];
        check_eq("si_res_data", 32'(res_data), 32'(exp_d));
        check_eq("si_res_id", 32'(res_id), 32'd0);
      end
      if (c == 4) check_eq("si_inflight_peak", 32'(inflight), 32'd4);
      tick();
    end
    idle(2);

    // Contention: alternating grants (or req0 only under fixed priority).
    exp_g = 0;
    for (int c = 0; c < 12; c++) begin
      req0_valid = 1'b1; req0_data = 2'd1;
      req1_valid = 1'b1; req1_data = 2'd2;
      @(negedge clk);
      check_eq("ct_req0_ready", 32'(req0_ready), 32'(exp_g == 0));
      check_eq("ct_req1_ready", 32'(req1_ready), 32'(exp_g == 1));
      if (res_valid) check_eq("ct_res_data", 32'(res_data), res_id ? 32'd4 : 32'd8);
`ifndef PIPE_ARB_PRIO_EN
      exp_g = 1 - exp_g;
`endif
      tick();
    end
    idle(LAT + 2);

    // Backpressure: stall 3 cycles with a full pipe, then release.
    acc0 = acc_cnt;
    for (int c = 0; c < 15; c++) begin
      req0_valid = (c < 8);
      req0_data = (c < 4) ? 2'(c) : 2'd1;
      res_ready = !(c >= 4 && c <= 6);
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        check_eq("bp_pipe_en", 32'(pipe_en), 32'd0);
        check_eq("bp_req0_ready", 32'(req0_ready), 32'd0);
        check_eq("bp_res_valid", 32'(res_valid), 32'd1);
        check_eq("bp_res_data_held", 32'(res_data), 32'd12);
      end
      if (c == 7) check_eq("bp_regrant", 32'(req0_ready), 32'd1);
      tick();
    end
    check_eq("bp_results", 32'(acc_cnt - acc0), 32'd5);
    check_eq("bp_sb_empty", 32'(sb_q.size()), 32'd0);
    idle(2);

    // Drain: three in flight, drain_done once all accepted, grants resume after release.
    for (int c = 0; c < 11; c++) begin
      req1_valid = (c < 3); req1_data = 2'(c);
      req0_valid = (c >= 3); req0_data = 2'd3;
      drain_req = (c >= 2 && c <= 8);
      @(negedge clk);
      if (c == 2) check_eq("dr_last_grant", 32'(req1_ready), 32'd1);
      if (c >= 3 && c <= 9) begin
        check_eq("dr_no_grant", 32'(req0_ready), 32'd0);
        check_eq("dr_done", 32'(drain_done), 32'(c >= 7 && c <= 8));
      end
      if (c == 10) check_eq("dr_resume", 32'(req0_ready), 32'd1);
      tick();
    end
    idle(LAT + 2);

    // Reset with four in flight: tags discarded, nothing emerges afterwards.
    for (int c = 0; c < 4; c++) begin
      req0_valid = 1'b1; req0_data = 2'(c);
      tick();
    end
    req0_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mr_res_valid", 32'(res_valid), 32'd0);
    check_eq("mr_inflight", 32'(inflight), 32'd0);
    check_eq("mr_pipe_en", 32'(pipe_en), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c <= LAT; c++) begin
      @(negedge clk);
      check_eq("mr_no_result", 32'(res_valid), 32'd0);
      tick();
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
